// File: rtl/irq_pending_ctrl.sv
// Request capture ahead of the 8-to-3 priority encoder: synchronise, edge-detect,
// latch pending events, apply mask, and flag overruns and stray acknowledges.
module irq_pending_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       mask_wr,
    input  logic [7:0] mask_in,
    input  logic       ack,
    input  logic [2:0] ack_idx,
    input  logic       ovf_clr,
    output logic [7:0] pend,
    output logic       irq,
    output logic [7:0] ovf,
    output logic       ack_err
);
    localparam int unsigned NCH = 8;

    logic [NCH-1:0] s1, s2, s3;
    logic [NCH-1:0] pending_q, mask_q;
    logic [NCH-1:0] rise, ack_vec, pending_d, ovf_set, ovf_d;
    logic           ack_err_d;

    // A rising edge sets pending even under an ack of the same channel.
    always_comb begin
        rise      = s2 & ~s3;
        ack_vec   = ack ? (NCH'(1) << ack_idx) : '0;
        pending_d = (pending_q & ~ack_vec) | rise;
        ovf_set   = rise & pending_q & ~ack_vec;
        ovf_d     = ovf_clr ? ovf_set : (ovf | ovf_set);
        ack_err_d = ack & ~pending_q[ack_idx];
    end

    assign pend = pending_q & mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            ovf       <= '0;
            irq       <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            s1        <= req;
            s2        <= s1;
            s3        <= s2;
            pending_q <= pending_d;
            if (mask_wr) begin
                mask_q <= mask_in;
            end
            ovf       <= ovf_d;
            irq       <= |pend;
            ack_err   <= ack_err_d;
        end
    end
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl with hand-computed expectations.
module tb_irq_pending_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       ack;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] pend;
    logic       irq;
    logic [7:0] ovf;
    logic       ack_err;

    int errors = 0;
    int checks = 0;

    irq_pending_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask_wr (mask_wr),
        .mask_in (mask_in),
        .ack     (ack),
        .ack_idx (ack_idx),
        .ovf_clr (ovf_clr),
        .pend    (pend),
        .irq     (irq),
        .ovf     (ovf),
        .ack_err (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack(input logic [2:0] idx);
        ack = 1'b1;
        ack_idx = idx;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask_wr = 1'b0; mask_in = '0;
        ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
        check("rst_pend", pend, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_ovf", ovf, 8'h00);
        check("rst_ackerr", {7'd0, ack_err}, 8'h00);

        // Single event latency on channel 5
        req = 8'h20;
        tick(2);
        check("lat_e1_pend", pend, 8'h00);
        tick();
        check("lat_e2_pend", pend, 8'h20);
        check("lat_e2_irq", {7'd0, irq}, 8'h00);
        req = 8'h00;
        tick();
        check("lat_e3_irq", {7'd0, irq}, 8'h01);
        do_ack(3'd5);
        check("ack5_pend", pend, 8'h00);
        check("ack5_err", {7'd0, ack_err}, 8'h00);
        tick();
        check("ack5_irq", {7'd0, irq}, 8'h00);

        // Priority handoff
        req = 8'h44;
        tick(3);
        check("prio_pend", pend, 8'h44);
        req = 8'h00;
        tick();
        check("prio_irq", {7'd0, irq}, 8'h01);
        do_ack(3'd6);
        check("prio_ack6", pend, 8'h04);
        do_ack(3'd2);
        check("prio_ack2", pend, 8'h00);
        check("prio_irq_hold", {7'd0, irq}, 8'h01);
        tick();
        check("prio_irq_low", {7'd0, irq}, 8'h00);

        // Masking hides but keeps the event
        mask_in = 8'hFB; mask_wr = 1'b1;
        tick();
        mask_wr = 1'b0;
        req = 8'h04;
        tick(3);
        req = 8'h00;
        check("mask_pend", pend, 8'h00);
        tick();
        check("mask_irq", {7'd0, irq}, 8'h00);
        mask_in = 8'hFF; mask_wr = 1'b1;
        tick();
        mask_wr = 1'b0;
        check("unmask_pend", pend, 8'h04);
        tick();
        check("unmask_irq", {7'd0, irq}, 8'h01);
        do_ack(3'd2);
        tick(2);

        // Overrun on channel 3
        req = 8'h08;
        tick(3);
        req = 8'h00;
        tick(2);
        req = 8'h08;
        tick(3);
        check("ovf_set", ovf, 8'h08);
        check("ovf_pend", pend, 8'h08);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 8'h00);
        check("ovf_clr_pend", pend, 8'h08);
        req = 8'h00;
        do_ack(3'd3);
        check("ovf_ack_pend", pend, 8'h00);
        tick(2);

        // Rise and ack on the same channel in the same cycle
        req = 8'h02;
        tick(3);
        req = 8'h00;
        tick(2);
        req = 8'h02;
        tick(2);
        do_ack(3'd1);
        check("setack_pend", pend, 8'h02);
        check("setack_ovf", ovf, 8'h00);
        check("setack_err", {7'd0, ack_err}, 8'h00);
        req = 8'h00;
        do_ack(3'd1);
        check("setack_clr", pend, 8'h00);
        tick(2);

        // Erroneous ack
        do_ack(3'd4);
        check("err_pulse", {7'd0, ack_err}, 8'h01);
        check("err_pend", pend, 8'h00);
        tick();
        check("err_drop", {7'd0, ack_err}, 8'h00);

        // Asynchronous reset mid-stream
        req = 8'hFF;
        tick(3);
        check("all_pend", pend, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pend", pend, 8'h00);
        check("async_rst_irq", {7'd0, irq}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_e1", pend, 8'h00);
        tick();
        check("post_rst_event", pend, 8'hFF);
        tick(3);
        check("post_rst_ovf", ovf, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
